// File: rtl/lisp_pkg.sv
// Shared Lisp machine types: cell tags, allocator error codes and cell sizing.
package lisp;

  localparam int unsigned addr_width = 16;
  localparam int unsigned data_width = 16;

  // Cell type tags as stored in the tag word of each cell.
  localparam logic [data_width-1:0] TYPE_NIL       = 16'h0000;
  localparam logic [data_width-1:0] TYPE_NUMBER    = 16'h0001;
  localparam logic [data_width-1:0] TYPE_SYMBOL    = 16'h0002;
  localparam logic [data_width-1:0] TYPE_CONS      = 16'h0003;
  localparam logic [data_width-1:0] TYPE_FUNC_PRIM = 16'h0004;

  typedef enum logic [1:0] {
    ALLOC_OK,
    ALLOC_OOM,
    ALLOC_BAD_TAG
  } alloc_err_e;

  localparam int unsigned CELL_SIZE_NUMBER = 2;
  localparam int unsigned CELL_SIZE_CONS   = 3;
  localparam int unsigned CELL_SIZE_PRIM   = 2;

  // Words occupied by a cell of the given tag; 0 marks a tag the allocator cannot build.
  function automatic logic [1:0] cell_size(input logic [data_width-1:0] tag);
    logic [1:0] size;
    size = 2'd0;
    if (tag == TYPE_NUMBER) begin
      size = 2'(CELL_SIZE_NUMBER);
    end else if (tag == TYPE_CONS) begin
      size = 2'(CELL_SIZE_CONS);
    end else if (tag == TYPE_FUNC_PRIM) begin
      size = 2'(CELL_SIZE_PRIM);
    end
    return size;
  endfunction

endpackage

// File: rtl/cell_allocator.sv
// Bump-pointer heap allocator: writes a cell one word per granted cycle, then reports its address.
module cell_allocator
  import lisp::*;
#(
  parameter int unsigned          ADDR_W     = lisp::addr_width,
  parameter int unsigned          DATA_W     = lisp::data_width,
  parameter logic [ADDR_W-1:0]    HEAP_BASE  = ADDR_W'(16'h0100),
  parameter logic [ADDR_W-1:0]    HEAP_LIMIT = ADDR_W'(16'h01FF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_done_i,
  input  logic              alloc_valid_i,
  output logic              alloc_ready_o,
  input  logic [DATA_W-1:0] alloc_tag_i,
  input  logic [DATA_W-1:0] alloc_word0_i,
  input  logic [DATA_W-1:0] alloc_word1_i,
  output logic              resp_valid_o,
  output logic [ADDR_W-1:0] resp_addr_o,
  output alloc_err_e        resp_err_o,
  output logic              mem_req_o,
  input  logic              mem_grant_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [ADDR_W-1:0] heap_ptr_o
);

  typedef enum logic [2:0] {
    StIdle,
    StWrTag,
    StWrW0,
    StWrW1,
    StDone
  } alloc_state_t;

  alloc_state_t      state_q, state_d;
  logic [ADDR_W-1:0] heap_ptr_q, heap_ptr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] tag_q, tag_d;
  logic [DATA_W-1:0] w0_q, w0_d;
  logic [DATA_W-1:0] w1_q, w1_d;
  logic [1:0]        size_q, size_d;
  alloc_err_e        err_q, err_d;

  logic [1:0]        req_size;
  logic [ADDR_W:0]   last_addr;
  logic              fits;

  // Fit test in one extra bit so a cell running past the top of the address space cannot wrap.
  always_comb begin
    req_size  = cell_size(alloc_tag_i);
    last_addr = {1'b0, heap_ptr_q} + (ADDR_W+1)'(req_size) - (ADDR_W+1)'(1);
    fits      = (last_addr <= {1'b0, HEAP_LIMIT});
  end

  // Next-state, heap pointer update and all outputs.
  always_comb begin
    state_d       = state_q;
    heap_ptr_d    = heap_ptr_q;
    base_d        = base_q;
    tag_d         = tag_q;
    w0_d          = w0_q;
    w1_d          = w1_q;
    size_d        = size_q;
    err_d         = err_q;
    alloc_ready_o = 1'b0;
    resp_valid_o  = 1'b0;
    resp_addr_o   = '0;
    resp_err_o    = ALLOC_OK;
    mem_req_o     = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;

    case (state_q)
      StIdle: begin
        // Ready is held low during reset so nothing appears acceptable before the heap is cleared.
        alloc_ready_o = boot_done_i && !rst;
        if (alloc_valid_i && boot_done_i) begin
          tag_d  = alloc_tag_i;
          w0_d   = alloc_word0_i;
          w1_d   = alloc_word1_i;
          size_d = req_size;
          base_d = heap_ptr_q;
          if (req_size == 2'd0) begin
            err_d   = ALLOC_BAD_TAG;
            state_d = StDone;
          end else if (!fits) begin
            err_d   = ALLOC_OOM;
            state_d = StDone;
          end else begin
            err_d   = ALLOC_OK;
            state_d = StWrTag;
          end
        end
      end
      StWrTag: begin
        mem_req_o   = 1'b1;
        mem_addr_o  = base_q;
        mem_wdata_o = tag_q;
        if (mem_grant_i) state_d = StWrW0;
      end
      StWrW0: begin
        mem_req_o   = 1'b1;
        mem_addr_o  = base_q + ADDR_W'(1);
        mem_wdata_o = w0_q;
        if (mem_grant_i) state_d = (tag_q == TYPE_CONS) ? StWrW1 : StDone;
      end
      StWrW1: begin
        mem_req_o   = 1'b1;
        mem_addr_o  = base_q + ADDR_W'(2);
        mem_wdata_o = w1_q;
        if (mem_grant_i) state_d = StDone;
      end
      StDone: begin
        resp_valid_o = 1'b1;
        resp_err_o   = err_q;
        // Pointer only moves once every word is committed, so a cell is never half-published.
        if (err_q == ALLOC_OK) begin
          resp_addr_o = base_q;
          heap_ptr_d  = heap_ptr_q + ADDR_W'(size_q);
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    mem_we_o = mem_req_o;
  end

  assign heap_ptr_o = heap_ptr_q;

  // State register with synchronous reset; reset abandons any partially written cell.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      heap_ptr_q <= HEAP_BASE;
      base_q     <= '0;
      tag_q      <= '0;
      w0_q       <= '0;
      w1_q       <= '0;
      size_q     <= '0;
      err_q      <= ALLOC_OK;
    end else begin
      state_q    <= state_d;
      heap_ptr_q <= heap_ptr_d;
      base_q     <= base_d;
      tag_q      <= tag_d;
      w0_q       <= w0_d;
      w1_q       <= w1_d;
      size_q     <= size_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_cell_allocator.sv
// Self-checking bench for cell_allocator: directed cases plus random allocations against a heap model.
module tb_cell_allocator;
  import lisp::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_done;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [15:0] alloc_tag;
  logic [15:0] alloc_word0;
  logic [15:0] alloc_word1;
  logic        resp_valid;
  logic [15:0] resp_addr;
  logic [1:0]  resp_err;
  logic        mem_req;
  logic        mem_grant;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] heap_ptr;

  int n_cmp  = 0;
  int n_fail = 0;
  int model_ptr;

  always #5 clk = ~clk;

  cell_allocator dut (
    .clk          (clk),
    .rst          (rst),
    .boot_done_i  (boot_done),
    .alloc_valid_i(alloc_valid),
    .alloc_ready_o(alloc_ready),
    .alloc_tag_i  (alloc_tag),
    .alloc_word0_i(alloc_word0),
    .alloc_word1_i(alloc_word1),
    .resp_valid_o (resp_valid),
    .resp_addr_o  (resp_addr),
    .resp_err_o   (resp_err),
    .mem_req_o    (mem_req),
    .mem_grant_i  (mem_grant),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .heap_ptr_o   (heap_ptr)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Words a cell of this tag occupies; 0 for tags that cannot be built.
  function automatic int ref_size(input logic [15:0] tag);
    if (tag == TYPE_NUMBER || tag == TYPE_FUNC_PRIM) return 2;
    if (tag == TYPE_CONS) return 3;
    return 0;
  endfunction

  // Issue one request and follow it to the response, checking every write against the model.
  // stall_k/stall_n withhold grant for stall_n cycles while word stall_k is pending.
  task automatic alloc(input logic [15:0] tag, input logic [15:0] w0, input logic [15:0] w1,
                       input bit rnd_grant, input int stall_k, input int stall_n);
    int          size, exp_err, k, stalls, held;
    logic [15:0] exp_base, prev_a, prev_d;
    logic [15:0] words [3];
    bit          prev_stall, got;
    size     = ref_size(tag);
    exp_base = 16'(model_ptr);
    if (size == 0) exp_err = 2;
    else if (model_ptr + size - 1 > 'h1FF) exp_err = 1;
    else exp_err = 0;
    words[0] = tag;
    words[1] = w0;
    words[2] = w1;
    k = 0; stalls = 0; held = 0; prev_stall = 0; got = 0;
    prev_a = '0; prev_d = '0;

    @(negedge clk);
    alloc_valid = 1'b1;
    alloc_tag   = tag;
    alloc_word0 = w0;
    alloc_word1 = w1;
    mem_grant   = 1'b1;
    check("ready_at_req", {31'b0, alloc_ready}, 32'd1);

    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      alloc_valid = 1'b0;
      if (stall_k == k && held < stall_n && mem_req) begin
        mem_grant = 1'b0;
        held++;
      end else if (rnd_grant) begin
        mem_grant = ($urandom_range(0, 2) != 0);
      end else begin
        mem_grant = 1'b1;
      end
      check("we_eq_req", {31'b0, mem_we}, {31'b0, mem_req});
      if (prev_stall) begin
        check("stall_addr", {16'b0, mem_addr}, {16'b0, prev_a});
        check("stall_data", {16'b0, mem_wdata}, {16'b0, prev_d});
      end
      if (exp_err != 0) begin
        check("err_no_req", {31'b0, mem_req}, 32'd0);
      end else if (mem_req) begin
        if (k < size) begin
          check("wr_addr", {16'b0, mem_addr}, 32'(exp_base) + 32'(k));
          check("wr_data", {16'b0, mem_wdata}, {16'b0, words[k]});
        end else begin
          check("wr_excess", {31'b0, mem_req}, 32'd0);
        end
      end
      prev_stall = mem_req && !mem_grant;
      prev_a     = mem_addr;
      prev_d     = mem_wdata;
      if (mem_req && mem_grant) k++;
      else if (mem_req) stalls++;
      if (resp_valid) begin
        check("resp_err", {30'b0, resp_err}, 32'(exp_err));
        check("resp_addr", {16'b0, resp_addr}, (exp_err == 0) ? 32'(exp_base) : 32'd0);
        check("resp_latency", 32'(cyc), (exp_err == 0) ? 32'(size + 1 + stalls) : 32'd1);
        check("word_count", 32'(k), (exp_err == 0) ? 32'(size) : 32'd0);
        got = 1;
        break;
      end
    end
    if (!got) check("resp_timeout", {31'b0, resp_valid}, 32'd1);
    if (exp_err == 0) model_ptr += size;

    @(negedge clk);
    mem_grant = 1'b1;
    check("resp_pulse", {31'b0, resp_valid}, 32'd0);
    check("heap_ptr", {16'b0, heap_ptr}, 32'(model_ptr));
    check("ready_after", {31'b0, alloc_ready}, {31'b0, boot_done});
  endtask

  initial begin
    rst         = 1'b1;
    boot_done   = 1'b0;
    alloc_valid = 1'b0;
    alloc_tag   = '0;
    alloc_word0 = '0;
    alloc_word1 = '0;
    mem_grant   = 1'b0;
    model_ptr   = 'h100;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, alloc_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_resp_addr", {16'b0, resp_addr}, 32'd0);
    check("rst_resp_err", {30'b0, resp_err}, 32'd0);
    check("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {16'b0, mem_wdata}, 32'd0);
    check("rst_heap_ptr", {16'b0, heap_ptr}, 32'h100);
    rst = 1'b0;

    // A request before boot completes must not be accepted.
    alloc_valid = 1'b1;
    alloc_tag   = TYPE_NUMBER;
    alloc_word0 = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("boot_ready", {31'b0, alloc_ready}, 32'd0);
      check("boot_mem_req", {31'b0, mem_req}, 32'd0);
      check("boot_resp", {31'b0, resp_valid}, 32'd0);
    end
    check("boot_heap_ptr", {16'b0, heap_ptr}, 32'h100);
    alloc_valid = 1'b0;
    boot_done   = 1'b1;

    // Directed: NUMBER, CONS, stalled NUMBER, unknown tag.
    alloc(TYPE_NUMBER, 16'h002A, 16'h0000, 1'b0, -1, 0);
    check("t1_heap_ptr", {16'b0, heap_ptr}, 32'h102);
    alloc(TYPE_CONS, 16'h0100, 16'h0000, 1'b0, -1, 0);
    check("t2_heap_ptr", {16'b0, heap_ptr}, 32'h105);
    alloc(TYPE_NUMBER, 16'h002A, 16'h0000, 1'b0, 1, 3);
    alloc(16'h0007, 16'h1111, 16'h2222, 1'b0, -1, 0);
    alloc(TYPE_FUNC_PRIM, 16'hBEEF, 16'h0000, 1'b1, -1, 0);

    // Random mix of tags, payloads and grant patterns.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] t;
      case ($urandom_range(0, 5))
        0, 1:    t = TYPE_NUMBER;
        2:       t = TYPE_CONS;
        3:       t = TYPE_FUNC_PRIM;
        4:       t = 16'($urandom_range(5, 255));
        default: t = TYPE_SYMBOL;
      endcase
      alloc(t, 16'($urandom), 16'($urandom), 1'b1, -1, 0);
    end

    // Fill the heap to exactly 0x1FE, then exercise the limit.
    if ((('h1FE - model_ptr) % 2) == 1) alloc(TYPE_CONS, 16'h0001, 16'h0002, 1'b0, -1, 0);
    while (model_ptr < 'h1FE) alloc(TYPE_NUMBER, 16'(model_ptr), 16'h0000, 1'b0, -1, 0);
    check("fill_heap_ptr", {16'b0, heap_ptr}, 32'h1FE);
    alloc(TYPE_CONS, 16'h0100, 16'h0102, 1'b0, -1, 0);
    check("oom_heap_ptr", {16'b0, heap_ptr}, 32'h1FE);
    alloc(TYPE_NUMBER, 16'h7777, 16'h0000, 1'b0, -1, 0);
    check("exact_fill_ptr", {16'b0, heap_ptr}, 32'h200);
    alloc(TYPE_NUMBER, 16'h0001, 16'h0000, 1'b1, -1, 0);
    alloc(TYPE_FUNC_PRIM, 16'h0002, 16'h0000, 1'b1, -1, 0);

    // Reset in the middle of a write abandons the cell and clears the heap.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 'h100;
    @(negedge clk);
    alloc_valid = 1'b1;
    alloc_tag   = TYPE_NUMBER;
    alloc_word0 = 16'h1234;
    mem_grant   = 1'b1;
    @(negedge clk);
    alloc_valid = 1'b0;
    check("mid_wrtag_req", {31'b0, mem_req}, 32'd1);
    @(negedge clk);
    check("mid_wrw0_addr", {16'b0, mem_addr}, 32'h101);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", {31'b0, alloc_ready}, 32'd0);
    check("mid_rst_req", {31'b0, mem_req}, 32'd0);
    check("mid_rst_we", {31'b0, mem_we}, 32'd0);
    check("mid_rst_resp", {31'b0, resp_valid}, 32'd0);
    check("mid_rst_addr", {16'b0, mem_addr}, 32'd0);
    check("mid_rst_wdata", {16'b0, mem_wdata}, 32'd0);
    check("mid_rst_heap", {16'b0, heap_ptr}, 32'h100);
    rst = 1'b0;
    alloc(TYPE_NUMBER, 16'h4321, 16'h0000, 1'b0, -1, 0);
    check("post_rst_ptr", {16'b0, heap_ptr}, 32'h102);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
